// File: rtl/mips_up.sv
// Multi-cycle 32-bit core: fixed FETCH/DECODE/EXEC/WB sequence, 4 clocks per instruction, IR fed directly.
// Optional multiplier for opcode 0x01 is built only when MIPS_UP_MUL_EN is defined.
module mips_up #(
  parameter int DMEM_DEPTH = 256,
  parameter int DMEM_AW    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IR,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata,
  output logic [1:0]  state,
  output logic        done,
  output logic [31:0] wb_data,
  output logic        illegal
);

  typedef enum logic [1:0] {FETCH = 2'd0, DECODE = 2'd1, EXEC = 2'd2, WB = 2'd3} state_e;

  localparam logic [6:0] OP_NOP   = 7'h00;
  localparam logic [6:0] OP_MUL   = 7'h01;
  localparam logic [6:0] OP_ADD   = 7'h02;
  localparam logic [6:0] OP_SUB   = 7'h03;
  localparam logic [6:0] OP_LOAD  = 7'h08;
  localparam logic [6:0] OP_STORE = 7'h10;

  state_e      state_q;
  logic [31:0] ir_q, a_q, b_q, res_q, wb_data_q;
  logic        done_q, illegal_q;
  logic [31:0] rf_q   [32];
  logic [31:0] dmem_q [DMEM_DEPTH];

  logic [6:0]         op;
  logic [4:0]         ra, rb;
  logic [DMEM_AW-1:0] midx;
  logic               op_legal, op_wr_reg, op_store;
  logic [31:0]        alu;
  logic               unused_ok;

  assign op   = ir_q[31:25];
  assign ra   = ir_q[24:20];
  assign rb   = ir_q[19:15];
  // maddr is ir_q[19:5]; only the low DMEM_AW bits select a word, so addresses wrap
  assign midx = ir_q[5 +: DMEM_AW];
  assign unused_ok = ^ir_q;

  always_comb begin
    op_legal  = 1'b0;
    op_wr_reg = 1'b0;
    op_store  = 1'b0;
    alu       = a_q;
    case (op)
      OP_NOP:   op_legal = 1'b1;
`ifdef MIPS_UP_MUL_EN
      OP_MUL: begin
        op_legal  = 1'b1;
        op_wr_reg = 1'b1;
        alu       = a_q * b_q;
      end
`endif
      OP_ADD: begin
        op_legal  = 1'b1;
        op_wr_reg = 1'b1;
        alu       = a_q + b_q;
      end
      OP_SUB: begin
        op_legal  = 1'b1;
        op_wr_reg = 1'b1;
        alu       = a_q - b_q;
      end
      OP_LOAD: begin
        op_legal  = 1'b1;
        op_wr_reg = 1'b1;
        alu       = dmem_q[midx];
      end
      OP_STORE: begin
        op_legal  = 1'b1;
        op_store  = 1'b1;
      end
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      wb_data_q <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= 32'(i);
    end else begin
      done_q <= 1'b0;
      case (state_q)
        FETCH: begin
          ir_q    <= IR;
          state_q <= DECODE;
        end
        DECODE: begin
          a_q     <= rf_q[ra];
          b_q     <= rf_q[rb];
          state_q <= EXEC;
        end
        EXEC: begin
          res_q   <= alu;
          done_q  <= 1'b1;
          state_q <= WB;
        end
        default: begin
          if (op_wr_reg) rf_q[ra] <= res_q;
          if (op_store) dmem_q[midx] <= res_q;
          if (op_wr_reg || op_store) wb_data_q <= res_q;
          illegal_q <= ~op_legal;
          state_q   <= FETCH;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign done      = done_q;
  assign wb_data   = wb_data_q;
  assign illegal   = illegal_q;
  assign dbg_rdata = rf_q[dbg_raddr];

endmodule

// File: tb/tb_mips_up.sv
// Bench for mips_up: table of instructions with expected commit results, plus reset-in-flight sequence.
module tb_mips_up;

`ifdef MIPS_UP_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IR = '0;
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata;
  logic [1:0]  state;
  logic        done;
  logic [31:0] wb_data;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] wb;
    logic        ill;
    logic [4:0]  r;
    logic [31:0] rv;
  } vec_t;

  typedef struct {
    logic [31:0] wb;
    logic        ill;
    logic [4:0]  r;
    logic [31:0] rv;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  mips_up #(.DMEM_DEPTH(256), .DMEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .IR(IR), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .state(state), .done(done), .wb_data(wb_data), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge while the core sits in FETCH.
  task automatic run_instr(input vec_t v, input string nm);
    exp_t e;
    int   cyc;
    bit   seen;
    e.wb = v.wb; e.ill = v.ill; e.r = v.r; e.rv = v.rv;
    chk({nm, ".fetch_state"}, 32'(state), 32'd0);
    IR = v.ir;
    sbq.push_back(e);
    @(posedge clk);
    #1 IR = $urandom;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    chk({nm, ".wb_latency"}, 32'(cyc), 32'd3);
    chk({nm, ".wb_state"}, 32'(state), 32'd3);
    @(negedge clk);
    e = sbq.pop_front();
    dbg_raddr = e.r;
    #1;
    chk({nm, ".done_clear"}, 32'(done), 32'd0);
    chk({nm, ".wb_data"}, wb_data, e.wb);
    chk({nm, ".illegal"}, 32'(illegal), 32'(e.ill));
    chk({nm, ".reg"}, dbg_rdata, e.rv);
  endtask

  function automatic vec_t mk(input logic [31:0] ir, input logic [31:0] wb, input logic ill,
                              input logic [4:0] r, input logic [31:0] rv);
    vec_t v;
    v.ir = ir; v.wb = wb; v.ill = ill; v.r = r; v.rv = rv;
    return v;
  endfunction

  initial begin
    vec_t v;
    tbl.push_back(mk(32'h1000_0000, 32'd0,  1'b0, 5'd0,  32'd0));   // LOAD r0<-mem[0]
    tbl.push_back(mk(32'h1100_0040, 32'd2,  1'b0, 5'd16, 32'd2));   // LOAD r16<-mem[2]
    tbl.push_back(mk(32'h1010_0020, 32'd1,  1'b0, 5'd1,  32'd1));   // LOAD r1<-mem[1]
    tbl.push_back(mk(32'h1000_00A0, 32'd5,  1'b0, 5'd0,  32'd5));   // LOAD r0<-mem[5]
    tbl.push_back(mk(32'h2000_0060, 32'd5,  1'b0, 5'd0,  32'd5));   // STORE mem[3]<-r0
    tbl.push_back(mk(32'h1040_0060, 32'd5,  1'b0, 5'd4,  32'd5));   // LOAD r4<-mem[3]
    tbl.push_back(mk(32'h1010_00E0, 32'd7,  1'b0, 5'd1,  32'd7));   // LOAD r1<-mem[7]
    tbl.push_back(mk(32'h1000_0140, 32'd10, 1'b0, 5'd0,  32'd10));  // LOAD r0<-mem[10]
    tbl.push_back(mk(32'h0600_8000, 32'd3,  1'b0, 5'd0,  32'd3));   // SUB r0=10-7
    tbl.push_back(mk(32'h0200_8000, MUL_EN ? 32'd21 : 32'd3, !MUL_EN, 5'd0, MUL_EN ? 32'd21 : 32'd3));
    tbl.push_back(mk(32'h0400_8000, MUL_EN ? 32'd28 : 32'd10, 1'b0, 5'd0, MUL_EN ? 32'd28 : 32'd10));
    tbl.push_back(mk(32'h0600_8000, MUL_EN ? 32'd21 : 32'd3, 1'b0, 5'd0, MUL_EN ? 32'd21 : 32'd3));
    tbl.push_back(mk(32'h7E00_0000, MUL_EN ? 32'd21 : 32'd3, 1'b1, 5'd0, MUL_EN ? 32'd21 : 32'd3));
    tbl.push_back(mk(32'h0000_0000, MUL_EN ? 32'd21 : 32'd3, 1'b0, 5'd0, MUL_EN ? 32'd21 : 32'd3));
    tbl.push_back(mk(32'h1050_2040, 32'd2,  1'b0, 5'd5,  32'd2));   // LOAD r5<-mem[0x102] wraps to 2
    tbl.push_back(mk(32'h0650_8000, 32'hFFFF_FFFB, 1'b0, 5'd5, 32'hFFFF_FFFB)); // SUB r5=2-7
    tbl.push_back(mk(32'h0452_0000, 32'd0,  1'b0, 5'd5,  32'd0));   // ADD r5+r4 wraps to 0

    repeat (3) @(negedge clk);
    #1;
    chk("rst.state",   32'(state),   32'd0);
    chk("rst.done",    32'(done),    32'd0);
    chk("rst.wb_data", wb_data,      32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_instr(tbl[i], $sformatf("vec%0d", i));

    // Reset during EXEC of LOAD r6<-mem[9]: nothing commits, state returns to FETCH at once.
    IR = 32'h1060_0120;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("midrst.exec_state", 32'(state), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst.state", 32'(state), 32'd0);
    chk("midrst.done",  32'(done),  32'd0);
    @(negedge clk);
    dbg_raddr = 5'd6;
    #1;
    chk("midrst.r6",   dbg_rdata, 32'd0);
    dbg_raddr = 5'd0;
    #1;
    chk("midrst.r0",   dbg_rdata, 32'd0);
    chk("midrst.wb",   wb_data,   32'd0);
    @(negedge clk);
    chk("midrst.done_hold", 32'(done), 32'd0);
    rst_n = 1'b1;
    v = mk(32'h1070_0060, 32'd3, 1'b0, 5'd7, 32'd3);  // mem[3] back to its reset value
    run_instr(v, "post_rst_load");
    v = mk(32'h1060_0120, 32'd9, 1'b0, 5'd6, 32'd9);
    run_instr(v, "post_rst_r6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
